pipe_regfile: RTL and testbench

Parametrised general-purpose register file for the pipelined core, with built-in operand forwarding and load-use hazard detection. Generalises the two-read-port file with a configurable number of read ports, data/address widths and an optional hardwired-zero register. Forwarding priority is EX, then MEM, then WB, then the array. It replaces the separate regfile plus ad-hoc bypass muxes in ID, and raises a stall request toward the PC and IF/ID stages.

---
 rtl/pipe_regfile.sv | 117 +++++++++++
 tb/tb_pipe_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_regfile.sv
// pipe_regfile: GPR file with EX/MEM/WB operand forwarding, load-use stall
// detection and a saturating stall-cycle counter.
module pipe_regfile #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned ZERO_REG    = 0,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wEnable_i,
  input  logic [ADDR_W-1:0]          wAddr_i,
  input  logic [DATA_W-1:0]          wData_i,
  input  logic                       exWReg_i,
  input  logic [ADDR_W-1:0]          exWRegAddr_i,
  input  logic [DATA_W-1:0]          exWData_i,
  input  logic                       exIsLoad_i,
  input  logic                       memWReg_i,
  input  logic [ADDR_W-1:0]          memWRegAddr_i,
  input  logic [DATA_W-1:0]          memWData_i,
  input  logic [NUM_RD-1:0]          rEnable_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rAddr_i,
  output logic [NUM_RD*DATA_W-1:0]   rData_o,
  output logic                       stallReq_o,
  output logic [STALL_CNT_W-1:0]     stallCnt_o,
  input  logic                       clrCnt_i
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [DATA_W-1:0]      mem_d [DEPTH];
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;
  logic [NUM_RD-1:0]      hazard;
  logic                   wr_allowed;

  // Next array contents: WB write, dropped when it targets a hardwired zero entry
  always_comb begin
    mem_d      = mem_q;
    wr_allowed = wEnable_i && !((ZERO_REG != 0) && (wAddr_i == '0));
    if (wr_allowed) begin
      mem_d[wAddr_i] = wData_i;
    end
  end

  // Array storage, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              ex_hit;
    logic              mem_hit;
    logic              wb_hit;
    logic [DATA_W-1:0] data;

    // Per-port read mux; later assignments win, so the order runs oldest to youngest
    always_comb begin
      addr    = rAddr_i[k*ADDR_W +: ADDR_W];
      is_zero = (ZERO_REG != 0) && (addr == '0);
      ex_hit  = exWReg_i && (exWRegAddr_i == addr);
      mem_hit = memWReg_i && (memWRegAddr_i == addr);
      wb_hit  = wEnable_i && (wAddr_i == addr);
      data    = mem_q[addr];
      if (wb_hit) begin
        data = wData_i;
      end
      if (mem_hit) begin
        data = memWData_i;
      end
      if (ex_hit && !exIsLoad_i) begin
        data = exWData_i;
      end
      if (rst || !rEnable_i[k] || is_zero) begin
        data = '0;
      end
    end

    assign hazard[k] = rEnable_i[k] && ex_hit && exIsLoad_i && !is_zero;
    assign rData_o[k*DATA_W +: DATA_W] = data;
  end

  assign stallReq_o = !rst && (|hazard);

  // Stall counter: clear has priority, otherwise saturating increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clrCnt_i) begin
      stall_cnt_d = '0;
    end else if (stallReq_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: default build, ZERO_REG=1 build and a
// 2-bit stall counter build, all sharing one stimulus bus.
module tb_pipe_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wEnable;
  logic [2:0]  wAddr;
  logic [15:0] wData;
  logic        exWReg;
  logic [2:0]  exWRegAddr;
  logic [15:0] exWData;
  logic        exIsLoad;
  logic        memWReg;
  logic [2:0]  memWRegAddr;
  logic [15:0] memWData;
  logic [1:0]  rEnable;
  logic [5:0]  rAddr;
  logic        clrCnt;

  logic [31:0] rdata_d, rdata_z, rdata_s;
  logic        stall_d, stall_z, stall_s;
  logic [15:0] cnt_d, cnt_z;
  logic [1:0]  cnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_regfile u_dut (
    .clk(clk), .rst(rst), .wEnable_i(wEnable), .wAddr_i(wAddr), .wData_i(wData),
    .exWReg_i(exWReg), .exWRegAddr_i(exWRegAddr), .exWData_i(exWData), .exIsLoad_i(exIsLoad),
    .memWReg_i(memWReg), .memWRegAddr_i(memWRegAddr), .memWData_i(memWData),
    .rEnable_i(rEnable), .rAddr_i(rAddr), .rData_o(rdata_d), .stallReq_o(stall_d),
    .stallCnt_o(cnt_d), .clrCnt_i(clrCnt)
  );

  pipe_regfile #(.ZERO_REG(1)) u_zero (
    .clk(clk), .rst(rst), .wEnable_i(wEnable), .wAddr_i(wAddr), .wData_i(wData),
    .exWReg_i(exWReg), .exWRegAddr_i(exWRegAddr), .exWData_i(exWData), .exIsLoad_i(exIsLoad),
    .memWReg_i(memWReg), .memWRegAddr_i(memWRegAddr), .memWData_i(memWData),
    .rEnable_i(rEnable), .rAddr_i(rAddr), .rData_o(rdata_z), .stallReq_o(stall_z),
    .stallCnt_o(cnt_z), .clrCnt_i(clrCnt)
  );

  pipe_regfile #(.STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .wEnable_i(wEnable), .wAddr_i(wAddr), .wData_i(wData),
    .exWReg_i(exWReg), .exWRegAddr_i(exWRegAddr), .exWData_i(exWData), .exIsLoad_i(exIsLoad),
    .memWReg_i(memWReg), .memWRegAddr_i(memWRegAddr), .memWData_i(memWData),
    .rEnable_i(rEnable), .rAddr_i(rAddr), .rData_o(rdata_s), .stallReq_o(stall_s),
    .stallCnt_o(cnt_s), .clrCnt_i(clrCnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wEnable = 0; wAddr = 0; wData = 0;
    exWReg = 0; exWRegAddr = 0; exWData = 0; exIsLoad = 0;
    memWReg = 0; memWRegAddr = 0; memWData = 0;
    rEnable = 0; rAddr = 0; clrCnt = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    rEnable = 2'b11;
    rAddr = {3'd5, 3'd3};
    #1;
    checks++; if (rdata_d !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata_d, 32'h0); end
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_d); end
    checks++; if (cnt_d !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt_d); end
    tick();
    tick();
    rst = 0;
    #1;
    checks++; if (rdata_d !== 32'h0) begin failures++; $display("FAIL reset_array got=%h exp=%h", rdata_d, 32'h0); end
    tick();
  endtask

  task automatic test_write();
    idle();
    wEnable = 1; wAddr = 3'd2; wData = 16'h1234;
    rEnable = 2'b11; rAddr = {3'd3, 3'd2};
    #1;
    checks++; if (rdata_d !== 32'h0000_1234) begin failures++; $display("FAIL write_through got=%h exp=%h", rdata_d, 32'h0000_1234); end
    tick();
    wEnable = 0;
    #1;
    checks++; if (rdata_d !== 32'h0000_1234) begin failures++; $display("FAIL write_array got=%h exp=%h", rdata_d, 32'h0000_1234); end
    rAddr = {3'd2, 3'd2};
    #1;
    checks++; if (rdata_d !== 32'h1234_1234) begin failures++; $display("FAIL write_same_addr got=%h exp=%h", rdata_d, 32'h1234_1234); end
    tick();
  endtask

  task automatic test_forward();
    idle();
    wEnable = 1; wAddr = 3'd4; wData = 16'd1;
    tick();
    wData = 16'd2;
    memWReg = 1; memWRegAddr = 3'd4; memWData = 16'd3;
    exWReg = 1; exWRegAddr = 3'd4; exWData = 16'd4;
    rEnable = 2'b11; rAddr = {3'd4, 3'd4};
    #1;
    checks++; if (rdata_d !== {16'd4, 16'd4}) begin failures++; $display("FAIL fwd_ex got=%h exp=%h", rdata_d, {16'd4, 16'd4}); end
    exWReg = 0;
    #1;
    checks++; if (rdata_d !== {16'd3, 16'd3}) begin failures++; $display("FAIL fwd_mem got=%h exp=%h", rdata_d, {16'd3, 16'd3}); end
    memWReg = 0;
    #1;
    checks++; if (rdata_d !== {16'd2, 16'd2}) begin failures++; $display("FAIL fwd_wb got=%h exp=%h", rdata_d, {16'd2, 16'd2}); end
    wEnable = 0;
    #1;
    checks++; if (rdata_d !== {16'd1, 16'd1}) begin failures++; $display("FAIL fwd_array got=%h exp=%h", rdata_d, {16'd1, 16'd1}); end
    rEnable = 2'b01;
    #1;
    checks++; if (rdata_d !== {16'd0, 16'd1}) begin failures++; $display("FAIL read_disable got=%h exp=%h", rdata_d, {16'd0, 16'd1}); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    wEnable = 1; wAddr = 3'd6; wData = 16'hABCD;
    tick();
    wEnable = 0;
    exWReg = 1; exIsLoad = 1; exWRegAddr = 3'd6; exWData = 16'hDEAD;
    memWReg = 1; memWRegAddr = 3'd6; memWData = 16'h5555;
    rEnable = 2'b11; rAddr = {3'd6, 3'd2};
    #1;
    checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_d); end
    checks++; if (rdata_d !== 32'h5555_1234) begin failures++; $display("FAIL lu_no_ex_fwd got=%h exp=%h", rdata_d, 32'h5555_1234); end
    memWReg = 0;
    #1;
    checks++; if (rdata_d !== 32'hABCD_1234) begin failures++; $display("FAIL lu_array got=%h exp=%h", rdata_d, 32'hABCD_1234); end
    tick(); tick(); tick();
    checks++; if (cnt_d !== 16'd3) begin failures++; $display("FAIL lu_cnt3 got=%0d exp=3", cnt_d); end
    rEnable = 2'b01;
    #1;
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL lu_disabled_port got=%b exp=0", stall_d); end
    rEnable = 2'b11; exIsLoad = 0;
    #1;
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL lu_nonload_stall got=%b exp=0", stall_d); end
    checks++; if (rdata_d !== 32'hDEAD_1234) begin failures++; $display("FAIL lu_nonload_fwd got=%h exp=%h", rdata_d, 32'hDEAD_1234); end
    tick();
    checks++; if (cnt_d !== 16'd3) begin failures++; $display("FAIL lu_cnt_hold got=%0d exp=3", cnt_d); end
    exIsLoad = 1; clrCnt = 1;
    tick();
    checks++; if (cnt_d !== 16'd0) begin failures++; $display("FAIL clr_priority got=%0d exp=0", cnt_d); end
    idle();
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    wEnable = 1; wAddr = 3'd0; wData = 16'hFFFF;
    rEnable = 2'b11; rAddr = {3'd0, 3'd0};
    #1;
    checks++; if (rdata_z !== 32'h0) begin failures++; $display("FAIL zero_wt got=%h exp=%h", rdata_z, 32'h0); end
    tick();
    wEnable = 0;
    #1;
    checks++; if (rdata_z !== 32'h0) begin failures++; $display("FAIL zero_read got=%h exp=%h", rdata_z, 32'h0); end
    checks++; if (rdata_d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL nonzero_r0 got=%h exp=%h", rdata_d, 32'hFFFF_FFFF); end
    exWReg = 1; exIsLoad = 1; exWRegAddr = 3'd0;
    #1;
    checks++; if (stall_z !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", stall_z); end
    checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL nonzero_r0_stall got=%b exp=1", stall_d); end
    clrCnt = 1;
    tick();
    idle();
    tick();
  endtask

  task automatic test_saturation();
    idle();
    exWReg = 1; exIsLoad = 1; exWRegAddr = 3'd6;
    rEnable = 2'b10; rAddr = {3'd6, 3'd0};
    repeat (5) tick();
    checks++; if (cnt_s !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", cnt_s); end
    checks++; if (cnt_d !== 16'd5) begin failures++; $display("FAIL wide_cnt got=%0d exp=5", cnt_d); end
    rAddr = {3'd6, 3'd2};
    #2;
    rst = 1;
    #1;
    checks++; if (cnt_s !== 2'd0) begin failures++; $display("FAIL async_cnt_s got=%0d exp=0", cnt_s); end
    checks++; if (cnt_d !== 16'd0) begin failures++; $display("FAIL async_cnt_d got=%0d exp=0", cnt_d); end
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL async_stall got=%b exp=0", stall_d); end
    rEnable = 2'b11;
    #1;
    checks++; if (rdata_d !== 32'h0) begin failures++; $display("FAIL async_rdata got=%h exp=%h", rdata_d, 32'h0); end
    tick();
    rst = 0;
    idle();
    rEnable = 2'b11; rAddr = {3'd6, 3'd2};
    #1;
    checks++; if (rdata_d !== 32'h0) begin failures++; $display("FAIL post_rst_array got=%h exp=%h", rdata_d, 32'h0); end
    tick();
  endtask

  initial begin
    idle();
    rst = 0;
    tick();
    test_reset();
    test_write();
    test_forward();
    test_load_use();
    test_zero_reg();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
